cdr_lock_ctrl: RTL and testbench
================================

# cdr_lock_ctrl

Acquisition/lock sequencer for the all-digital CDR core. It watches the per-baud `sample_en` strobe and the bang-bang phase-detector votes, and judges lock over fixed windows of baud samples. It switches the loop-filter proportional/integral shift gains between acquisition and tracking sets, and holds or clears the loop when the tile is disabled or acquisition times out. It sits beside the CDR core in the top-level wrapper and drives the core's gain/hold/clear controls plus status pins.

## Interface
- `WIN_LOG2`, 5, log2 of samples per evaluation window (32)
- `MIN_TRANS`, 8, minimum early+late votes in a window for it to be "good"
- `BAL_TH`, 4, maximum |early − late| in a window for it to be "good"
- `LOCK_WINS`, 4, consecutive good windows needed to declare lock
- `UNLOCK_WINS`, 2, consecutive bad windows in LOCKED needed to drop lock
- `ACQ_TIMEOUT`, 64, windows allowed in ACQ before forced loop restart
- `KP_ACQ`/`KI_ACQ`, 4/8, acquisition shift gains (4-bit)
- `KP_TRK`/`KI_TRK`, 6/11, tracking shift gains (4-bit)
- `clk`  in  1  system clock (~50 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  tile enable; low forces IDLE
- `sample_en`  in  1  one-cycle baud strobe from CDR core
- `pd_vote`  in  2  PD vote, qualified by `sample_en`: 00 none, 01 early, 10 late, 11 treated as none
- `kp_shift`  out  4  proportional shift to loop filter
- `ki_shift`  out  4  integral shift to loop filter
- `loop_hold`  out  1  freeze loop filter/NCO update
- `loop_clr`  out  1  one-cycle pulse: clear integrator/NCO accumulator
- `locked`  out  1  lock status
- `lost`  out  1  sticky: lock was lost since last enable
- `timeout`  out  1  one-cycle pulse on acquisition timeout
- `state`  out  2  00 IDLE, 01 ACQ, 10 LOCKED

## Operation
- All outputs registered. Reset values: state=IDLE, kp/ki = KP_ACQ/KI_ACQ, loop_hold=1, loop_clr=0, locked=0, lost=0, timeout=0; all counters 0.
- Window accumulators (active only in ACQ/LOCKED, only on `sample_en`): sample count (WIN_LOG2 bits), early count E, late count L (WIN_LOG2+1 bits each, cannot overflow).
- Window closes on the `sample_en` whose sample count = 2^WIN_LOG2 − 1; that pulse's vote is included. Good window: (E+L) ≥ MIN_TRANS and |E−L| ≤ BAL_TH, computed at WIN_LOG2+2 bits unsigned. Accumulators restart at 0 on the same edge.
- IDLE: loop_hold=1, gains = ACQ set, counters cleared. ena=1 → ACQ, with loop_clr=1 for the first ACQ cycle.
- ACQ: loop_hold=0, gains = ACQ set.
  - Good window → good_cnt+1; reaching LOCK_WINS → LOCKED.
  - Bad window → good_cnt=0.
  - acq_win_cnt increments per closed window. If it reaches ACQ_TIMEOUT without lock, then timeout=1 and loop_clr=1 for one cycle, acq_win_cnt=0, good_cnt=0, and the state stays ACQ.
  - The lock transition takes priority over timeout on the same window.
- LOCKED: locked=1, gains = TRK set.
  - Bad window → bad_cnt+1; reaching UNLOCK_WINS → ACQ with locked=0, lost=1, all window/acq counters cleared, no loop_clr.
  - Good window → bad_cnt=0.
- `lost` clears only on reset or on entry to IDLE.
- ena=0 in any state → IDLE on the next edge: accumulators cleared, partial window discarded, locked=0, no loop_clr. `sample_en` is ignored while ena=0.
- A vote of 11 counts toward the sample count but toward neither E nor L.

## Timing
- Window decision and all resulting state/output changes appear on the clock edge ending the cycle in which the closing `sample_en` is high (1-cycle latency).
- Gains switch on the same edge as the `state` change; `locked` and `state` are always coherent.
- loop_clr and timeout are exactly one clk cycle wide, never back-to-back (≥ one window apart).
- ena high → ACQ with loop_clr on the first edge where ena=1 is sampled. ena low → IDLE/hold on the first edge where ena=0 is sampled.
- Async reset mid-window drops all state immediately; after release, behaviour is as from power-up.

## Test plan
- Reset with ena=1: hold all outputs at reset values during rst_n=0. After release, 1 cycle later state=01, loop_clr pulse, loop_hold=0, kp/ki=4/8.
- Feed 32-sample windows of 8 early + 8 late votes: after the 4th window close, next cycle state=10, locked=1, kp/ki=6/11.
- From LOCKED, feed windows of 16 early/0 late: two windows → state=01, locked=0, lost=1, kp/ki=4/8. One bad window followed by one good window → stays LOCKED.
- In ACQ, feed all-"none" votes for 64 windows: timeout and loop_clr are each 1-cycle pulses after window 64, state stays 01. A further 64 windows gives a second pulse.
- Boundary windows:
  - E+L=8, |E−L|=4 → counted good.
  - E+L=7 → counted bad.
  - 32 votes of 11 → counted bad.
- Drop ena mid-window while LOCKED: next cycle state=00, loop_hold=1, locked=0, lost=0. Raise ena: loop_clr pulse, and the window count restarts from 0.

Source files
------------

// File: rtl/cdr_lock_ctrl.sv
// rtl/cdr_lock_ctrl.sv - CDR acquisition/lock sequencer driving loop-filter gains, hold and clear
module cdr_lock_ctrl #(
    parameter int unsigned WIN_LOG2    = 5,
    parameter int unsigned MIN_TRANS   = 8,
    parameter int unsigned BAL_TH      = 4,
    parameter int unsigned LOCK_WINS   = 4,
    parameter int unsigned UNLOCK_WINS = 2,
    parameter int unsigned ACQ_TIMEOUT = 64,
    parameter logic [3:0]  KP_ACQ      = 4'd4,
    parameter logic [3:0]  KI_ACQ      = 4'd8,
    parameter logic [3:0]  KP_TRK      = 4'd6,
    parameter logic [3:0]  KI_TRK      = 4'd11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sample_en,
    input  logic [1:0] pd_vote,
    output logic [3:0] kp_shift,
    output logic [3:0] ki_shift,
    output logic       loop_hold,
    output logic       loop_clr,
    output logic       locked,
    output logic       lost,
    output logic       timeout,
    output logic [1:0] state
);
    localparam int unsigned SW = WIN_LOG2;
    localparam int unsigned CW = WIN_LOG2 + 1;
    localparam int unsigned AW = WIN_LOG2 + 2;
    localparam int unsigned GW = $clog2(LOCK_WINS + 1);
    localparam int unsigned BW = $clog2(UNLOCK_WINS + 1);
    localparam int unsigned TW = $clog2(ACQ_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACQ    = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    state_t        st, st_nx;
    logic [SW-1:0] samp_cnt, samp_nx;
    logic [CW-1:0] e_cnt, e_nx, l_cnt, l_nx, e_sum, l_sum;
    logic [GW-1:0] good_cnt, good_nx, good_inc;
    logic [BW-1:0] bad_cnt, bad_nx, bad_inc;
    logic [TW-1:0] acq_win_cnt, acq_nx, acq_inc;
    logic [AW-1:0] tot, ext_e, ext_l, diff;
    logic          smp, win_close, good, lost_nx, clr_nx, tmo_nx;

    // The closing vote is folded in before judging so the window sees all 2^WIN_LOG2 samples
    assign smp       = sample_en && (st != S_IDLE);
    assign e_sum     = e_cnt + CW'(smp && (pd_vote == 2'b01));
    assign l_sum     = l_cnt + CW'(smp && (pd_vote == 2'b10));
    assign win_close = smp && (samp_cnt == '1);
    assign ext_e     = AW'(e_sum);
    assign ext_l     = AW'(l_sum);
    assign tot       = ext_e + ext_l;
    assign diff      = (ext_e >= ext_l) ? (ext_e - ext_l) : (ext_l - ext_e);
    assign good      = (tot >= AW'(MIN_TRANS)) && (diff <= AW'(BAL_TH));
    assign good_inc  = good_cnt + GW'(1);
    assign bad_inc   = bad_cnt + BW'(1);
    assign acq_inc   = acq_win_cnt + TW'(1);

    always_comb begin
        st_nx   = st;
        samp_nx = samp_cnt;
        e_nx    = e_cnt;
        l_nx    = l_cnt;
        good_nx = good_cnt;
        bad_nx  = bad_cnt;
        acq_nx  = acq_win_cnt;
        lost_nx = lost;
        clr_nx  = 1'b0;
        tmo_nx  = 1'b0;
        if (!ena) begin
            st_nx   = S_IDLE;
            samp_nx = '0;
            e_nx    = '0;
            l_nx    = '0;
            good_nx = '0;
            bad_nx  = '0;
            acq_nx  = '0;
            lost_nx = 1'b0;
        end else begin
            if (smp) begin
                samp_nx = samp_cnt + SW'(1);
                e_nx    = win_close ? '0 : e_sum;
                l_nx    = win_close ? '0 : l_sum;
            end
            case (st)
                S_IDLE: begin
                    st_nx   = S_ACQ;
                    clr_nx  = 1'b1;
                    lost_nx = 1'b0;
                end
                S_ACQ: begin
                    if (win_close) begin
                        good_nx = good ? good_inc : '0;
                        acq_nx  = acq_inc;
                        // Lock wins over timeout when both land on the same window
                        if (good && (good_inc == GW'(LOCK_WINS))) begin
                            st_nx   = S_LOCKED;
                            good_nx = '0;
                            bad_nx  = '0;
                            acq_nx  = '0;
                        end else if (acq_inc == TW'(ACQ_TIMEOUT)) begin
                            tmo_nx  = 1'b1;
                            clr_nx  = 1'b1;
                            acq_nx  = '0;
                            good_nx = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (win_close) begin
                        if (good) begin
                            bad_nx = '0;
                        end else if (bad_inc == BW'(UNLOCK_WINS)) begin
                            st_nx   = S_ACQ;
                            lost_nx = 1'b1;
                            bad_nx  = '0;
                            good_nx = '0;
                            acq_nx  = '0;
                        end else begin
                            bad_nx = bad_inc;
                        end
                    end
                end
                default: st_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            samp_cnt    <= '0;
            e_cnt       <= '0;
            l_cnt       <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            acq_win_cnt <= '0;
            kp_shift    <= KP_ACQ;
            ki_shift    <= KI_ACQ;
            loop_hold   <= 1'b1;
            loop_clr    <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            st          <= st_nx;
            samp_cnt    <= samp_nx;
            e_cnt       <= e_nx;
            l_cnt       <= l_nx;
            good_cnt    <= good_nx;
            bad_cnt     <= bad_nx;
            acq_win_cnt <= acq_nx;
            kp_shift    <= (st_nx == S_LOCKED) ? KP_TRK : KP_ACQ;
            ki_shift    <= (st_nx == S_LOCKED) ? KI_TRK : KI_ACQ;
            loop_hold   <= (st_nx == S_IDLE);
            loop_clr    <= clr_nx;
            locked      <= (st_nx == S_LOCKED);
            lost        <= lost_nx;
            timeout     <= tmo_nx;
        end
    end

    assign state = st;
endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// tb/tb_cdr_lock_ctrl.sv - scoreboard bench for cdr_lock_ctrl
module tb_cdr_lock_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       sample_en = 1'b0;
    logic [1:0] pd_vote = 2'b00;
    logic [3:0] kp_shift, ki_shift;
    logic       loop_hold, loop_clr, locked, lost, timeout;
    logic [1:0] state;

    cdr_lock_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_en(sample_en), .pd_vote(pd_vote),
        .kp_shift(kp_shift), .ki_shift(ki_shift), .loop_hold(loop_hold), .loop_clr(loop_clr),
        .locked(locked), .lost(lost), .timeout(timeout), .state(state)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         tag;
        string      name;
        logic [1:0] st;
        logic       lk;
        logic       ls;
        logic       clr;
        logic       tmo;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   exp_clr = 0, exp_tmo = 0, seen_clr = 0, seen_tmo = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(logic [1:0] st, logic lk, logic ls, logic clr, logic tmo);
        exp_t e;
        e.tag = 0; e.name = ""; e.st = st; e.lk = lk; e.ls = ls; e.clr = clr; e.tmo = tmo;
        return e;
    endfunction

    function automatic logic [14:0] pack_exp(exp_t e);
        logic [3:0] kp, ki;
        kp = (e.st == 2'b10) ? 4'd6 : 4'd4;
        ki = (e.st == 2'b10) ? 4'd11 : 4'd8;
        return {e.st, kp, ki, (e.st == 2'b00), e.clr, e.lk, e.ls, e.tmo};
    endfunction

    // Monitor: pops every expectation due this cycle and compares against the DUT
    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] got, want;
        if (loop_clr) seen_clr++;
        if (timeout) seen_tmo++;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            got  = {state, kp_shift, ki_shift, loop_hold, loop_clr, locked, lost, timeout};
            want = pack_exp(e);
            checks++;
            if (e.tag != cyc)
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.tag);
            else if (got === want)
                passed++;
            else
                $display("FAIL %s @%0d: got st/kp/ki/hold/clr/lk/lost/tmo=%b required %b",
                         e.name, cyc, got, want);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(int tag, string name, exp_t e);
        e.tag  = tag;
        e.name = name;
        q.push_back(e);
        if (e.clr) exp_clr++;
        if (e.tmo) exp_tmo++;
    endtask

    task automatic expect_entry(string name, exp_t e);
        exp_t s;
        s = e; s.clr = 1'b0; s.tmo = 1'b0;
        expect_at(cyc + 1, name, e);
        if (e.clr || e.tmo) expect_at(cyc + 2, {name, "_end"}, s);
    endtask

    // One 32-sample window: ne early, nl late, n3 votes of 11, rest none
    task automatic window(int ne, int nl, int n3, exp_t post, string name);
        for (int i = 0; i < 32; i++) begin
            sample_en = 1'b1;
            pd_vote = (i < ne) ? 2'd1 : (i < ne + nl) ? 2'd2 : (i < ne + nl + n3) ? 2'd3 : 2'd0;
            if (i == 31) begin
                expect_at(cyc, {name, "_pre"}, cur);
                expect_entry(name, post);
            end
            tick();
        end
        sample_en = 1'b0;
        pd_vote = 2'd0;
        cur = post; cur.clr = 1'b0; cur.tmo = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t idle, acq, acq_l, lck, lck_l;
        idle  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        acq   = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        acq_l = mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        lck   = mk(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        lck_l = mk(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset held with ena high and strobes present
        ena = 1'b1;
        cur = idle;
        tick(); tick();
        expect_at(cyc, "reset_a", idle);
        sample_en = 1'b1; pd_vote = 2'd1;
        tick();
        expect_at(cyc, "reset_b", idle);
        tick();
        sample_en = 1'b0; pd_vote = 2'd0;
        rst_n = 1'b1;
        expect_at(cyc, "release_idle", idle);
        expect_entry("acq_entry", mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        tick(); tick();
        cur = acq;

        // Acquire: four balanced windows
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq, "acq_good");
        window(8, 8, 0, lck, "lock");

        // Bad/good interleave keeps lock, two consecutive bad drop it
        window(16, 0, 0, lck, "lk_bad1");
        window(8, 8, 0, lck, "lk_good");
        window(16, 0, 0, lck, "lk_bad_again");
        window(16, 0, 0, acq_l, "unlock");

        // Boundary windows
        for (int w = 0; w < 3; w++) window(6, 2, 0, acq_l, "bnd_sum8_diff4");
        window(6, 2, 0, lck_l, "bnd_lock");
        window(4, 3, 0, lck_l, "sum7_bad1");
        window(4, 3, 0, acq_l, "sum7_unlock");
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq_l, "pre11_good");
        window(0, 0, 32, acq_l, "all11_bad");
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq_l, "post11_good");
        window(7, 2, 0, acq_l, "diff5_bad");
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq_l, "post5_good");
        window(8, 8, 0, lck_l, "relock_a");

        // Drop ena mid-window while locked
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1; pd_vote = 2'd1;
            tick();
        end
        ena = 1'b0;
        expect_entry("ena_off", idle);
        tick();
        for (int i = 0; i < 3; i++) tick();
        expect_at(cyc, "idle_ignores_samples", idle);
        tick();
        sample_en = 1'b0; pd_vote = 2'd0;
        ena = 1'b1;
        expect_entry("reena", mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        tick(); tick();
        cur = acq;
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq, "restart_good");
        window(8, 8, 0, lck, "relock_b");

        // Acquisition timeout, twice
        ena = 1'b0;
        expect_entry("ena_off2", idle);
        tick();
        ena = 1'b1;
        expect_entry("reena2", mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        tick(); tick();
        cur = acq;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 63; w++) window(0, 0, 0, acq, "acq_none");
            window(0, 0, 0, mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b1), "timeout");
        end

        // Async reset mid-window
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'b1; pd_vote = 2'd2;
            tick();
        end
        #3 rst_n = 1'b0;
        expect_at(cyc, "async_reset", idle);
        sample_en = 1'b0; pd_vote = 2'd0;
        tick();
        rst_n = 1'b1;
        expect_entry("post_reset_acq", mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        tick(); tick();
        cur = acq;
        for (int w = 0; w < 3; w++) window(8, 8, 0, acq, "fresh_good");
        window(8, 8, 0, lck, "fresh_lock");
        tick(); tick();

        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL pending_expectations: got %0d left required 0", q.size());
        checks++;
        if (seen_clr == exp_clr) passed++;
        else $display("FAIL loop_clr_pulses: got %0d required %0d", seen_clr, exp_clr);
        checks++;
        if (seen_tmo == exp_tmo) passed++;
        else $display("FAIL timeout_pulses: got %0d required %0d", seen_tmo, exp_tmo);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
